// File: rtl/conv_pkg.sv
// Shared definitions for the streaming KxK convolution engine.
//   state_e         : control FSM encoding
//   conv_latency()  : beat-to-result latency for a kernel edge K
//   conv_ow_ok()    : true when the output width can hold a full-precision sum
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  // Multiply register + one register per tree level + output register.
  function automatic int unsigned conv_latency(input int unsigned k);
    return 2 + $clog2(k * k);
  endfunction

  // A K*K-term sum of DWxWW products grows by ceil(log2(K*K)) bits.
  function automatic bit conv_ow_ok(input int unsigned ow, input int unsigned dw,
                                    input int unsigned ww, input int unsigned k);
    return ow >= (dw + ww + $clog2(k * k));
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered signed binary adder tree with a valid bit travelling alongside.
//   clk, rstn  : clock, async active-low reset
//   in_valid   : leaf data valid
//   in_data    : NL packed signed leaves of IW bits, leaf 0 in the LS lane
//   out_valid  : sum valid, LV cycles after in_valid
//   out_data   : signed sum, IW+LV bits
//   busy_c     : any level currently holds a valid token
module conv_adder_tree #(
  parameter  int unsigned NL     = 25,
  parameter  int unsigned IW     = 16,
  localparam int unsigned LV     = $clog2(NL),
  localparam int unsigned SW_OUT = IW + LV
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [NL*IW-1:0]         in_data,
  output logic                     out_valid,
  output logic signed [SW_OUT-1:0] out_data,
  output logic                     busy_c
);

  logic [LV-1:0] vld_q, vld_d;

  // Valid shift register, one stage per tree level.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int l = 1; l < int'(LV); l++) vld_d[l] = vld_q[l-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Level l has 2**(LV-l-1) nodes, each one bit wider than its children.
  // Missing leaves (NL not a power of two) are tied to zero.
  for (genvar l = 0; l < int'(LV); l++) begin : g_lvl
    localparam int unsigned NO = 2 ** (LV - l - 1);
    localparam int unsigned SW = IW + l + 1;
    for (genvar i = 0; i < int'(NO); i++) begin : g_node
      logic signed [SW-2:0] a, b;
      logic signed [SW-1:0] sum_d, sum_q;
      if (l == 0) begin : g_leaf
        if (2 * i < NL) begin : g_a
          assign a = $signed(in_data[2*i*IW +: IW]);
        end else begin : g_az
          assign a = '0;
        end
        if (2 * i + 1 < NL) begin : g_b
          assign b = $signed(in_data[(2*i+1)*IW +: IW]);
        end else begin : g_bz
          assign b = '0;
        end
      end else begin : g_inner
        assign a = g_lvl[l-1].g_node[2*i].sum_q;
        assign b = g_lvl[l-1].g_node[2*i+1].sum_q;
      end
      always_comb sum_d = SW'(a) + SW'(b);
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sum_q <= '0;
        else       sum_q <= sum_d;
      end
    end
  end

  assign out_data  = g_lvl[LV-1].g_node[0].sum_q;
  assign out_valid = vld_q[LV-1];
  assign busy_c    = |vld_q;

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK signed convolution engine.
//   clk, rstn    : clock, async active-low reset
//   start        : one-cycle pulse, latches cfg_n / cfg_stride / weight_keep
//   cfg_n        : feature-map edge N (K..NMAX)
//   cfg_stride   : stride S (1..3)
//   weight_keep  : 1 = reuse the stored kernel, skip loading
//   weight_valid, weight : kernel beats, row-major
//   taps_valid, taps     : one feature-map column, top row in the MS lane
//   dout, ovalid : sign-extended dot product and its valid
//   busy         : start accepted until done
//   done         : one-cycle pulse once the last result has left
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter  int unsigned K    = 5,
  parameter  int unsigned DW   = 8,
  parameter  int unsigned WW   = 8,
  parameter  int unsigned OW   = 32,
  parameter  int unsigned NMAX = 32,
  localparam int unsigned NW   = $clog2(NMAX + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [NW-1:0]     cfg_n,
  input  logic [1:0]        cfg_stride,
  input  logic              weight_keep,
  input  logic              weight_valid,
  input  logic [WW-1:0]     weight,
  input  logic              taps_valid,
  input  logic [K*DW-1:0]   taps,
  output logic [OW-1:0]     dout,
  output logic              ovalid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned KK = K * K;
  localparam int unsigned KW = $clog2(KK);
  localparam int unsigned PW = DW + WW;
  localparam int unsigned TW = PW + $clog2(KK);

  if (!conv_ow_ok(OW, DW, WW, K)) begin : g_ow_chk
    $error("conv_stream_engine: OW too narrow for K, DW, WW");
  end

  state_e               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [1:0]           s_q, s_d;
  logic [NW-1:0]        col_q, col_d, band_q, band_d;
  logic [1:0]           col_ph_q, col_ph_d, band_ph_q, band_ph_d;
  logic [KW-1:0]        wcnt_q, wcnt_d;
  logic signed [WW-1:0] kern_q [KK];
  logic signed [WW-1:0] kern_d [KK];
  logic signed [DW-1:0] win_q  [KK];
  logic signed [DW-1:0] win_d  [KK];
  logic                 win_vld_q, win_vld_d;
  logic [KK*PW-1:0]     prod_q, prod_d;
  logic                 mult_vld_q, mult_vld_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [OW-1:0]        dout_q, dout_d;
  logic                 ovalid_q, ovalid_d;

  logic                 tree_vld, tree_busy_c;
  logic signed [TW-1:0] tree_sum;

  logic cfg_ok_c, col_last_c, band_last_c, out_col_c;

  assign cfg_ok_c    = (cfg_n >= NW'(K)) && (cfg_n <= NW'(NMAX)) && (cfg_stride != 2'd0);
  assign col_last_c  = (col_q == n_q - NW'(1));
  assign band_last_c = (band_q == n_q - NW'(K));
  assign out_col_c   = (col_q >= NW'(K - 1));

  // FSM, counters, kernel file and window shift register.
  // col_ph/band_ph track (col-K+1) mod S and band mod S without a divider.
  always_comb begin : p_next
    state_d    = state_q;
    n_d        = n_q;
    s_d        = s_q;
    col_d      = col_q;
    band_d     = band_q;
    col_ph_d   = col_ph_q;
    band_ph_d  = band_ph_q;
    wcnt_d     = wcnt_q;
    kern_d     = kern_q;
    win_d      = win_q;
    win_vld_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mult_vld_d = win_vld_q;
    ovalid_d   = tree_vld;
    dout_d     = tree_vld ? OW'(tree_sum) : dout_q;

    case (state_q)
      ST_IDLE: begin
        if (start && cfg_ok_c) begin
          n_d       = cfg_n;
          s_d       = cfg_stride;
          col_d     = '0;
          band_d    = '0;
          col_ph_d  = '0;
          band_ph_d = '0;
          wcnt_d    = '0;
          busy_d    = 1'b1;
          state_d   = weight_keep ? ST_RUN : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (weight_valid) begin
          kern_d[wcnt_q] = weight;
          if (wcnt_q == KW'(KK - 1)) begin
            wcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            wcnt_d = wcnt_q + KW'(1);
          end
        end
      end
      ST_RUN: begin
        if (taps_valid) begin
          // Column 0 is the oldest; the new column enters at column K-1.
          for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K) - 1; c++) win_d[r*K+c] = win_q[r*K+c+1];
            win_d[r*K+K-1] = taps[(K-1-r)*DW +: DW];
          end
          win_vld_d = out_col_c && (col_ph_q == 2'd0) && (band_ph_q == 2'd0);
          if (out_col_c) col_ph_d = (col_ph_q == s_q - 2'd1) ? 2'd0 : col_ph_q + 2'd1;
          if (col_last_c) begin
            col_d     = '0;
            col_ph_d  = '0;
            band_d    = band_q + NW'(1);
            band_ph_d = (band_ph_q == s_q - 2'd1) ? 2'd0 : band_ph_q + 2'd1;
            if (band_last_c) state_d = ST_DRAIN;
          end else begin
            col_d = col_q + NW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Output register excluded: done lands one cycle after the last ovalid.
        if (!win_vld_q && !mult_vld_q && !tree_busy_c) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full-precision signed products, one per kernel tap.
  always_comb begin : p_mul
    prod_d = '0;
    for (int i = 0; i < int'(KK); i++) begin
      prod_d[i*PW +: PW] = PW'(PW'(win_q[i]) * PW'(kern_q[i]));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : p_regs
    if (!rstn) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      s_q        <= '0;
      col_q      <= '0;
      band_q     <= '0;
      col_ph_q   <= '0;
      band_ph_q  <= '0;
      wcnt_q     <= '0;
      for (int i = 0; i < int'(KK); i++) begin
        kern_q[i] <= '0;
        win_q[i]  <= '0;
      end
      win_vld_q  <= 1'b0;
      prod_q     <= '0;
      mult_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= '0;
      ovalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      s_q        <= s_d;
      col_q      <= col_d;
      band_q     <= band_d;
      col_ph_q   <= col_ph_d;
      band_ph_q  <= band_ph_d;
      wcnt_q     <= wcnt_d;
      kern_q     <= kern_d;
      win_q      <= win_d;
      win_vld_q  <= win_vld_d;
      prod_q     <= prod_d;
      mult_vld_q <= mult_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dout_q     <= dout_d;
      ovalid_q   <= ovalid_d;
    end
  end

  conv_adder_tree #(
    .NL (KK),
    .IW (PW)
  ) u_tree (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (mult_vld_q),
    .in_data   (prod_q),
    .out_valid (tree_vld),
    .out_data  (tree_sum),
    .busy_c    (tree_busy_c)
  );

  assign dout   = dout_q;
  assign ovalid = ovalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
module tb_conv_stream_engine;

  localparam int K    = 5;
  localparam int DW   = 8;
  localparam int WW   = 8;
  localparam int OW   = 32;
  localparam int NMAX = 32;
  localparam int NCW  = $clog2(NMAX + 1);
  localparam int L    = 2 + $clog2(K * K);

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [NCW-1:0]    cfg_n;
  logic [1:0]        cfg_stride;
  logic              weight_keep;
  logic              weight_valid;
  logic [WW-1:0]     weight;
  logic              taps_valid;
  logic [K*DW-1:0]   taps;
  logic [OW-1:0]     dout;
  logic              ovalid;
  logic              busy;
  logic              done;

  conv_stream_engine #(.K(K), .DW(DW), .WW(WW), .OW(OW), .NMAX(NMAX)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_n(cfg_n), .cfg_stride(cfg_stride),
    .weight_keep(weight_keep), .weight_valid(weight_valid), .weight(weight),
    .taps_valid(taps_valid), .taps(taps), .dout(dout), .ovalid(ovalid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference data: image and kernel as plain signed integers.
  int img [NMAX][NMAX];
  int w   [K*K];
  int exp_q[$];

  // Observed results.
  int got_q[$];
  int got_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  logic busy_at_done = 1'b0;
  logic busy_at_start = 1'b0;

  always @(negedge clk) begin
    if (ovalid === 1'b1) begin
      got_q.push_back($signed(dout));
      got_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  function automatic int px(input int v);
    logic [7:0] t;
    t = v[7:0];
    return int'($signed(t));
  endfunction

  // Direct definition of a strided valid convolution, raster order.
  function automatic void model(input int n, input int s);
    exp_q.delete();
    for (int oi = 0; oi <= n - K; oi += s)
      for (int oj = 0; oj <= n - K; oj += s) begin
        int acc = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) acc += img[oi+r][oj+c] * w[r*K+c];
        exp_q.push_back(acc);
      end
  endfunction

  task automatic fill_rand();
    for (int r = 0; r < NMAX; r++)
      for (int c = 0; c < NMAX; c++) img[r][c] = px($urandom);
    for (int i = 0; i < K*K; i++) w[i] = px($urandom);
  endtask

  // Drives one full job; abort_band >= 0 returns mid-stream for reset tests.
  task automatic run_conv(input int n, input int s, input int keep, input int bub,
                          input int junk_w, input int abort_band,
                          output int beat5, output int timed_out);
    int d0, beats;
    beat5 = -1; timed_out = 0; beats = 0;
    got_q.delete(); got_cyc.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; cfg_n = NCW'(n); cfg_stride = 2'(s); weight_keep = keep[0];
    @(negedge clk);
    start = 1'b0; weight_keep = 1'b0;
    busy_at_start = busy;
    if (keep == 0) begin
      for (int i = 0; i < K*K; i++) begin
        while (bub > 0 && $urandom_range(99) < bub) begin
          weight_valid = 1'b0; @(negedge clk);
        end
        weight_valid = 1'b1; weight = WW'(w[i]);
        @(negedge clk);
      end
      weight_valid = 1'b0;
    end
    for (int b = 0; b <= n - K; b++) begin
      for (int c = 0; c < n; c++) begin
        if (b == abort_band && c == 5) begin
          taps_valid = 1'b0; weight_valid = 1'b0;
          return;
        end
        while (bub > 0 && $urandom_range(99) < bub) begin
          taps_valid = 1'b0; @(negedge clk);
        end
        taps_valid = 1'b1;
        for (int r = 0; r < K; r++) taps[(K-1-r)*DW +: DW] = DW'(img[b+r][c]);
        if (junk_w != 0) begin
          weight_valid = 1'b1; weight = WW'($urandom);
        end
        @(negedge clk);
        beats++;
        if (beats == 5) beat5 = cyc;
      end
    end
    taps_valid = 1'b0; weight_valid = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) timed_out = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; cfg_n = '0; cfg_stride = '0; weight_keep = 1'b0;
    weight_valid = 1'b0; weight = '0; taps_valid = 1'b0; taps = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL reset_dout: got %0h need 0", dout); end
    n_cmp++; if (ovalid !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid: got %b need 0", ovalid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b need 0", done); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ovalid !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy=%b ovalid=%b done=%b need 0", busy, ovalid, done);
    end
  endtask

  task automatic test_ones();
    int b5, to;
    for (int i = 0; i < K*K; i++) w[i] = 1;
    for (int r = 0; r < NMAX; r++) for (int c = 0; c < NMAX; c++) img[r][c] = 1;
    run_conv(28, 1, 0, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0) begin n_bad++; $display("FAIL ones_timeout: no done seen"); end
    n_cmp++; if (busy_at_start !== 1'b1) begin n_bad++; $display("FAIL ones_busy: got %b need 1", busy_at_start); end
    n_cmp++; if (got_q.size() != 576) begin n_bad++; $display("FAIL ones_count: got %0d need 576", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] != 25) begin n_bad++; $display("FAIL ones_val[%0d]: got %0d need 25", i, got_q[i]); end
    end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_cyc[0] - b5 != L) begin n_bad++; $display("FAIL ones_latency: got %0d need %0d", got_cyc[0] - b5, L); end
      n_cmp++; if (done_cyc - got_cyc[got_cyc.size()-1] != 1) begin
        n_bad++; $display("FAIL ones_done_gap: got %0d need 1", done_cyc - got_cyc[got_cyc.size()-1]);
      end
    end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL ones_busy_at_done: got %b need 0", busy_at_done); end
  endtask

  task automatic test_keep();
    int b5, to;
    run_conv(12, 1, 1, 0, 1, -1, b5, to);
    n_cmp++; if (to != 0) begin n_bad++; $display("FAIL keep_timeout: no done seen"); end
    n_cmp++; if (got_q.size() != 64) begin n_bad++; $display("FAIL keep_count: got %0d need 64", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] != 25) begin n_bad++; $display("FAIL keep_val[%0d]: got %0d need 25", i, got_q[i]); end
    end
  endtask

  task automatic test_stride2();
    int b5, to, e;
    for (int i = 0; i < K*K; i++) w[i] = 0;
    w[2*K+2] = 1;
    for (int r = 0; r < NMAX; r++) for (int c = 0; c < NMAX; c++) img[r][c] = px(r*28 + c);
    run_conv(28, 2, 0, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0) begin n_bad++; $display("FAIL s2_timeout: no done seen"); end
    n_cmp++; if (got_q.size() != 144) begin n_bad++; $display("FAIL s2_count: got %0d need 144", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 144; i++) begin
      e = img[2 + 2*(i/12)][2 + 2*(i%12)];
      n_cmp++; if (got_q[i] != e) begin n_bad++; $display("FAIL s2_val[%0d]: got %0d need %0d", i, got_q[i], e); end
    end
  endtask

  task automatic test_extremes();
    int b5, to;
    for (int r = 0; r < NMAX; r++) for (int c = 0; c < NMAX; c++) img[r][c] = -128;
    for (int i = 0; i < K*K; i++) w[i] = -128;
    run_conv(6, 1, 0, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0 || got_q.size() != 4) begin n_bad++; $display("FAIL neg_count: got %0d need 4 (timeout=%0d)", got_q.size(), to); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] != 409600) begin n_bad++; $display("FAIL neg_val[%0d]: got %0d need 409600", i, got_q[i]); end
    end
    for (int i = 0; i < K*K; i++) w[i] = 127;
    run_conv(6, 1, 0, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0 || got_q.size() != 4) begin n_bad++; $display("FAIL mix_count: got %0d need 4 (timeout=%0d)", got_q.size(), to); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] != -406400) begin n_bad++; $display("FAIL mix_val[%0d]: got %0d need -406400", i, got_q[i]); end
    end
  endtask

  task automatic test_bubbles();
    int b5, to, n, s;
    int ref_q[$];
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      n = $urandom_range(14, K);
      s = $urandom_range(3, 1);
      model(n, s);
      run_conv(n, s, 0, 0, 0, -1, b5, to);
      ref_q = got_q;
      run_conv(n, s, 0, 50, 0, -1, b5, to);
      n_cmp++; if (to != 0) begin n_bad++; $display("FAIL bub_timeout: trial %0d", t); end
      n_cmp++; if (ref_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL nobub_count: got %0d need %0d (n=%0d s=%0d)", ref_q.size(), exp_q.size(), n, s);
      end
      n_cmp++; if (got_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL bub_count: got %0d need %0d (n=%0d s=%0d)", got_q.size(), exp_q.size(), n, s);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i < ref_q.size()) begin
          n_cmp++; if (ref_q[i] != exp_q[i]) begin n_bad++; $display("FAIL nobub_val[%0d]: got %0d need %0d", i, ref_q[i], exp_q[i]); end
        end
        if (i < got_q.size()) begin
          n_cmp++; if (got_q[i] != exp_q[i]) begin n_bad++; $display("FAIL bub_val[%0d]: got %0d need %0d", i, got_q[i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_boundary();
    int b5, to, d0;
    int bad_n [3] = '{4, 33, 28};
    int bad_s [3] = '{1, 1, 0};
    // Illegal configurations must be ignored.
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; cfg_n = NCW'(bad_n[i]); cfg_stride = 2'(bad_s[i]);
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_cfg_busy[%0d]: got %b need 0", i, busy); end
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL bad_cfg_done: got %0d need %0d", done_cnt, d0); end
    // Smallest and largest maps.
    fill_rand();
    model(K, 1);
    run_conv(K, 1, 0, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0 || got_q.size() != 1) begin n_bad++; $display("FAIL nk_count: got %0d need 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] != exp_q[0]) begin n_bad++; $display("FAIL nk_val: got %0d need %0d", got_q[0], exp_q[0]); end
    end
    model(NMAX, 3);
    run_conv(NMAX, 3, 1, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0 || got_q.size() != 100) begin n_bad++; $display("FAIL nmax_count: got %0d need 100", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] != exp_q[i]) begin n_bad++; $display("FAIL nmax_val[%0d]: got %0d need %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int b5, to, nres, d0;
    fill_rand();
    run_conv(28, 1, 0, 0, 0, 10, b5, to);
    rstn = 1'b0;
    #1;
    n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL mid_rst_dout: got %0h need 0", dout); end
    n_cmp++; if (ovalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovalid: got %b need 0", ovalid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b need 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b need 0", done); end
    nres = got_q.size();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (got_q.size() != nres) begin n_bad++; $display("FAIL mid_rst_ovalid_after: got %0d need %0d", got_q.size(), nres); end
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL mid_rst_done_after: got %0d need %0d", done_cnt, d0); end
    // Reset clears the kernel, so reusing it yields zero.
    run_conv(5, 1, 1, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0 || got_q.size() != 1) begin n_bad++; $display("FAIL kern_clr_count: got %0d need 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] != 0) begin n_bad++; $display("FAIL kern_clr_val: got %0d need 0", got_q[0]); end
    end
    fill_rand();
    model(28, 1);
    run_conv(28, 1, 0, 0, 0, -1, b5, to);
    n_cmp++; if (to != 0 || got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL reload_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] != exp_q[i]) begin n_bad++; $display("FAIL reload_val[%0d]: got %0d need %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_keep();
    test_stride2();
    test_extremes();
    test_bubbles();
    test_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
